// File: rtl/seg_if.sv
// Bus bundle between the CPU write port and the 7-segment scan controller.
// Carries the write strobe, display options and the scanned pin outputs.
interface seg_if;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic        blank_lz;
  logic        pending;
  logic        frame_start;
  logic [11:0] seg_out;

  modport master (
    output wr_en, wr_data, wr_dp, blank_lz,
    input  pending, frame_start, seg_out
  );

  modport slave (
    input  wr_en, wr_data, wr_dp, blank_lz,
    output pending, frame_start, seg_out
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode 7-segment scan controller.
// Double-buffered hex value, per-slot blanking, optional leading-zero blanking.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input logic clk,
  input logic rst,
  seg_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q;
  logic [15:0]   active_q, shadow_q;
  logic [3:0]    adp_q, sdp_q;
  logic          pend_q, fs_q;
  logic [11:0]   seg_q, seg_d;
  logic          slot_end, frame_end;
  logic          lz_hit;
  logic [3:0]    nib;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [7:0] f;
    case (n)
      4'h0: f = 8'hC0;
      4'h1: f = 8'hF9;
      4'h2: f = 8'hA4;
      4'h3: f = 8'hB0;
      4'h4: f = 8'h99;
      4'h5: f = 8'h92;
      4'h6: f = 8'h82;
      4'h7: f = 8'hF8;
      4'h8: f = 8'h80;
      4'h9: f = 8'h90;
      4'hA: f = 8'h88;
      4'hB: f = 8'h83;
      4'hC: f = 8'hC6;
      4'hD: f = 8'hA1;
      4'hE: f = 8'h86;
      default: f = 8'h8E;
    endcase
    return f[6:0];
  endfunction

  assign slot_end  = cnt_q == CW'(SCAN_DIV - 1);
  assign frame_end = slot_end && idx_q == 2'd3;
  assign nib       = active_q[idx_q*4 +: 4];

  always_comb begin
    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    state_d = (cnt_d < CW'(BLANK_CYC)) ? BLANK : SHOW;
    lz_hit  = 1'b0;
    unique case (1'b1)
      idx_q == 2'd0: lz_hit = 1'b0;
      idx_q == 2'd1: lz_hit = active_q[15:4] == '0;
      idx_q == 2'd2: lz_hit = active_q[15:8] == '0;
      idx_q == 2'd3: lz_hit = active_q[15:12] == '0;
    endcase
    seg_d = 12'hFFF;
    // a zero-blanked digit suppresses its dp as well
    if (state_q == SHOW && !(bus.blank_lz && lz_hit))
      seg_d = {~(4'b0001 << idx_q), ~adp_q[idx_q], font(nib)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      active_q <= '0;
      shadow_q <= '0;
      adp_q    <= '0;
      sdp_q    <= '0;
      pend_q   <= 1'b0;
      fs_q     <= 1'b0;
      seg_q    <= 12'hFFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      fs_q    <= frame_end;
      if (slot_end)
        idx_q <= idx_q + 2'd1;
      // a write landing on the boundary bypasses the shadow
      if (bus.wr_en && frame_end) begin
        active_q <= bus.wr_data;
        adp_q    <= bus.wr_dp;
        shadow_q <= bus.wr_data;
        sdp_q    <= bus.wr_dp;
        pend_q   <= 1'b0;
      end else if (bus.wr_en) begin
        shadow_q <= bus.wr_data;
        sdp_q    <= bus.wr_dp;
        pend_q   <= 1'b1;
      end else if (frame_end && pend_q) begin
        active_q <= shadow_q;
        adp_q    <= sdp_q;
        pend_q   <= 1'b0;
      end
    end
  end

  assign bus.pending     = pend_q;
  assign bus.frame_start = fs_q;
  assign bus.seg_out     = seg_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2 (32-cycle frame).
// Frame-position reference model, vector table, corner sequences, random run.
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg_if bus ();

  seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [7:0] FONT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int tests = 0;
  int fails = 0;

  int          m_p    = 0;
  logic [15:0] m_act  = '0;
  logic [15:0] m_sh   = '0;
  logic [3:0]  m_adp  = '0;
  logic [3:0]  m_sdp  = '0;
  logic        m_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // p = position within the 32-cycle frame of the cycle being rendered
  function automatic logic [11:0] model_seg(input int p, input logic [15:0] v,
                                            input logic [3:0] dp, input logic lz);
    int i, c, nb;
    logic [3:0] sel;
    logic [7:0] f;
    i = p / 8;
    c = p % 8;
    if (c < 2) return 12'hFFF;
    if (lz && i > 0 && (int'(v) >> (4 * i)) == 0) return 12'hFFF;
    nb  = (int'(v) >> (4 * i)) & 15;
    sel = 4'hF ^ 4'(1 << i);
    f   = FONT[nb];
    return {sel, ~dp[i], f[6:0]};
  endfunction

  task automatic step(input logic we, input logic [15:0] d,
                      input logic [3:0] dp, input logic lz, input logic r);
    logic [11:0] e_seg;
    logic        e_fs;
    rst          = r;
    bus.wr_en    = we;
    bus.wr_data  = d;
    bus.wr_dp    = dp;
    bus.blank_lz = lz;
    @(posedge clk);
    if (r) begin
      e_seg  = 12'hFFF;
      e_fs   = 1'b0;
      m_p    = 0;
      m_act  = '0;
      m_sh   = '0;
      m_adp  = '0;
      m_sdp  = '0;
      m_pend = 1'b0;
    end else begin
      e_seg = model_seg(m_p, m_act, m_adp, lz);
      e_fs  = (m_p == 31);
      if (we && m_p == 31) begin
        m_act  = d;
        m_adp  = dp;
        m_pend = 1'b0;
      end else if (we) begin
        m_sh   = d;
        m_sdp  = dp;
        m_pend = 1'b1;
      end else if (m_p == 31 && m_pend) begin
        m_act  = m_sh;
        m_adp  = m_sdp;
        m_pend = 1'b0;
      end
      m_p = (m_p + 1) % 32;
    end
    #1;
    chk("seg_out", 32'(bus.seg_out), 32'(e_seg));
    chk("pending", 32'(bus.pending), 32'(m_pend));
    chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
  endtask

  task automatic idle(input logic lz);
    step(1'b0, 16'h0, 4'h0, lz, 1'b0);
  endtask

  task automatic run_to(input int p, input logic lz);
    for (int k = 0; k < 40 && m_p != p; k++) idle(lz);
  endtask

  task automatic wait_fs(input logic lz);
    int k;
    k = 0;
    while (!bus.frame_start && k < 64) begin
      idle(lz);
      k++;
    end
    if (!bus.frame_start) chk("fs_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [3:0]  dp;
    logic        lz;
    int          dig;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{16'h1234, 4'h0, 1'b0, 0, 12'hE99};
    vecs[1]  = '{16'h1234, 4'h0, 1'b0, 1, 12'hDB0};
    vecs[2]  = '{16'h1234, 4'h0, 1'b0, 2, 12'hBA4};
    vecs[3]  = '{16'h1234, 4'h0, 1'b0, 3, 12'h7F9};
    vecs[4]  = '{16'h0050, 4'h0, 1'b1, 3, 12'hFFF};
    vecs[5]  = '{16'h0050, 4'h0, 1'b1, 2, 12'hFFF};
    vecs[6]  = '{16'h0050, 4'h0, 1'b1, 1, 12'hD92};
    vecs[7]  = '{16'h0050, 4'h0, 1'b1, 0, 12'hEC0};
    vecs[8]  = '{16'h0000, 4'h0, 1'b1, 0, 12'hEC0};
    vecs[9]  = '{16'h0000, 4'h0, 1'b1, 1, 12'hFFF};
    vecs[10] = '{16'h0008, 4'h1, 1'b0, 0, 12'hE00};
    vecs[11] = '{16'h0008, 4'h1, 1'b0, 1, 12'hDC0};
    vecs[12] = '{16'h0050, 4'h0, 1'b0, 3, 12'h7C0};
    vecs[13] = '{16'h00D0, 4'hF, 1'b1, 2, 12'hFFF};

    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    chk("rst_seg", 32'(bus.seg_out), 32'hFFF);
    chk("rst_pend", 32'(bus.pending), 32'd0);
    for (int k = 0; k < 40; k++) idle(1'b0);

    foreach (vecs[k]) begin
      step(1'b0, 16'h0, 4'h0, vecs[k].lz, 1'b1);
      step(1'b1, vecs[k].d, vecs[k].dp, vecs[k].lz, 1'b0);
      chk($sformatf("vec%0d_pend", k), 32'(bus.pending), 32'd1);
      wait_fs(vecs[k].lz);
      for (int j = 0; j < vecs[k].dig * 8 + 6; j++) idle(vecs[k].lz);
      chk($sformatf("vec%0d", k), 32'(bus.seg_out), 32'(vecs[k].exp));
    end

    // write exactly on the frame-boundary cycle
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    run_to(31, 1'b0);
    step(1'b1, 16'h0007, 4'h0, 1'b0, 1'b0);
    chk("bnd_pend", 32'(bus.pending), 32'd0);
    chk("bnd_fs", 32'(bus.frame_start), 32'd1);
    for (int j = 0; j < 6; j++) begin
      idle(1'b0);
      chk("bnd_pend_low", 32'(bus.pending), 32'd0);
    end
    chk("bnd_show", 32'(bus.seg_out), 32'hEF8);

    // two writes in one frame, last wins
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    run_to(3, 1'b0);
    step(1'b1, 16'hAAAA, 4'h0, 1'b0, 1'b0);
    run_to(10, 1'b0);
    step(1'b1, 16'hBBBB, 4'h0, 1'b0, 1'b0);
    wait_fs(1'b0);
    for (int j = 0; j < 6; j++) idle(1'b0);
    chk("last_wins", 32'(bus.seg_out), 32'hE83);

    // reset during digit2 SHOW with a pending write
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    run_to(5, 1'b0);
    step(1'b1, 16'h1234, 4'h0, 1'b0, 1'b0);
    run_to(20, 1'b0);
    chk("pre_rst_pend", 32'(bus.pending), 32'd1);
    step(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    chk("mid_rst_seg", 32'(bus.seg_out), 32'hFFF);
    chk("mid_rst_pend", 32'(bus.pending), 32'd0);
    for (int j = 0; j < 3; j++) idle(1'b0);
    chk("restart_d0", 32'(bus.seg_out), 32'hEC0);
    for (int j = 0; j < 40; j++) idle(1'b0);

    // randomized traffic against the model
    begin
      logic lz;
      logic [15:0] d;
      lz = 1'b0;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 199) == 0) lz = ~lz;
        d = 16'($urandom);
        if ($urandom_range(0, 1) == 1) d = d & 16'h00F0;
        step($urandom_range(0, 15) == 0, d, 4'($urandom), lz,
             $urandom_range(0, 499) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
